// File: rtl/scr1_tapc_pkg.sv
// Shared TAPC data-register types: DR update FSM encoding and the shift-counter width rule.
package scr1_tapc_pkg;

   typedef enum logic [1:0] {
      SCR1_TAPC_DR_IDLE  = 2'd0,
      SCR1_TAPC_DR_CAPT  = 2'd1,
      SCR1_TAPC_DR_SHIFT = 2'd2
   } type_scr1_tapc_dr_fsm_e;

   // One extra bit beyond the width needed to hold SCR1_WIDTH, so overlong scans are visible.
   function automatic int scr1_tapc_cnt_w(input int width);
      return $clog2(width + 1) + 1;
   endfunction

   localparam int SCR1_TAPC_DR_WIDTH_DEF = 8;
   localparam int SCR1_TAPC_CNT_W_DEF    = $clog2(SCR1_TAPC_DR_WIDTH_DEF + 1) + 1;

endpackage

// File: rtl/scr1_tapc_dr_shadow_reg_if.sv
// TAP FSM strobes and DR data bundle; master is the TAP/FSM side, slave is the data register.
interface scr1_tapc_dr_shadow_reg_if #(
   parameter int SCR1_WIDTH = 8
);
   import scr1_tapc_pkg::*;
   localparam int SCR1_CNT_W = scr1_tapc_cnt_w(SCR1_WIDTH);

   logic                  fsm_dr_select;
   logic                  fsm_dr_capture;
   logic                  fsm_dr_shift;
   logic                  fsm_dr_update;
   logic                  din_serial;
   logic [SCR1_WIDTH-1:0] din_parallel;
   logic                  dout_serial;
   logic [SCR1_WIDTH-1:0] dout_parallel;
   logic                  update_vld;
   logic                  len_err;
   logic                  len_err_sticky;
   logic [SCR1_CNT_W-1:0] shift_cnt;

   modport master (
      output fsm_dr_select, fsm_dr_capture, fsm_dr_shift, fsm_dr_update,
      output din_serial, din_parallel,
      input  dout_serial, dout_parallel, update_vld, len_err, len_err_sticky, shift_cnt
   );

   modport slave (
      input  fsm_dr_select, fsm_dr_capture, fsm_dr_shift, fsm_dr_update,
      input  din_serial, din_parallel,
      output dout_serial, dout_parallel, update_vld, len_err, len_err_sticky, shift_cnt
   );

endinterface

// File: rtl/scr1_tapc_dr_shadow_reg_chk.sv
// Simulation checker: DR control and data inputs must never be X/Z outside reset.
module scr1_tapc_dr_shadow_reg_chk #(
   parameter int SCR1_WIDTH = 8
) (
   input logic                  clk,
   input logic                  rst_n,
   input logic                  rst_n_sync,
   input logic                  fsm_dr_select,
   input logic                  fsm_dr_capture,
   input logic                  fsm_dr_shift,
   input logic                  fsm_dr_update,
   input logic                  din_serial,
   input logic [SCR1_WIDTH-1:0] din_parallel
);

   a_inputs_known : assert property (@(negedge clk) disable iff (!rst_n)
      !$isunknown({rst_n_sync, fsm_dr_select, fsm_dr_capture, fsm_dr_shift,
                   fsm_dr_update, din_serial, din_parallel}));

endmodule

// File: rtl/scr1_tapc_shift_core.sv
// DR shift stage: parallel capture, serial shift in the configured direction, serial output tap.
module scr1_tapc_shift_core #(
   parameter int                    SCR1_WIDTH       = 8,
   parameter logic [SCR1_WIDTH-1:0] SCR1_RESET_VALUE = '0,
   parameter bit                    SCR1_MSB_FIRST   = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rst_n_sync,
   input  logic                  i_capture,
   input  logic                  i_shift,
   input  logic                  i_din_serial,
   input  logic [SCR1_WIDTH-1:0] i_din_parallel,
   output logic [SCR1_WIDTH-1:0] o_stage,
   output logic                  o_dout_serial
);

   logic [SCR1_WIDTH-1:0] r_stage;
   logic [SCR1_WIDTH-1:0] w_shift_next;

   generate
      if (SCR1_WIDTH == 1) begin : g_w1
         assign w_shift_next  = i_din_serial;
         assign o_dout_serial = r_stage[0];
      end else if (SCR1_MSB_FIRST) begin : g_msb
         assign w_shift_next  = {r_stage[SCR1_WIDTH-2:0], i_din_serial};
         assign o_dout_serial = r_stage[SCR1_WIDTH-1];
      end else begin : g_lsb
         assign w_shift_next  = {i_din_serial, r_stage[SCR1_WIDTH-1:1]};
         assign o_dout_serial = r_stage[0];
      end
   endgenerate

   // Shift stage register; the caller has already resolved strobe priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stage <= SCR1_RESET_VALUE;
      end else if (!rst_n_sync) begin
         r_stage <= SCR1_RESET_VALUE;
      end else if (i_capture) begin
         r_stage <= i_din_parallel;
      end else if (i_shift) begin
         r_stage <= w_shift_next;
      end else begin
         r_stage <= r_stage;
      end
   end

   assign o_stage = r_stage;

endmodule

// File: rtl/scr1_tapc_dr_shadow_reg.sv
// TAPC data register with optional shadow stage, update strobe and shift-length checking.
module scr1_tapc_dr_shadow_reg
   import scr1_tapc_pkg::*;
#(
   parameter int                    SCR1_WIDTH       = 8,
   parameter logic [SCR1_WIDTH-1:0] SCR1_RESET_VALUE = '0,
   parameter bit                    SCR1_UPDATE_EN   = 1'b1,
   parameter bit                    SCR1_MSB_FIRST   = 1'b0,
   parameter bit                    SCR1_LEN_CHECK   = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         rst_n_sync,
   scr1_tapc_dr_shadow_reg_if.slave     dr_if
);

   localparam int                    SCR1_CNT_W = scr1_tapc_cnt_w(SCR1_WIDTH);
   localparam logic [SCR1_CNT_W-1:0] LP_CNT_MAX  = '1;
   localparam logic [SCR1_CNT_W-1:0] LP_CNT_FULL = SCR1_CNT_W'(SCR1_WIDTH);

   type_scr1_tapc_dr_fsm_e r_fsm;
   logic [SCR1_CNT_W-1:0]  r_shift_cnt;
   logic                   r_update_vld;
   logic                   r_len_err;
   logic                   r_len_err_sticky;
   logic [SCR1_WIDTH-1:0]  w_stage;
   logic                   w_capture;
   logic                   w_shift;
   logic                   w_update;
   logic                   w_len_ok;
   logic                   w_upd_ok;

   // Capture beats shift beats update; nothing happens unless this DR is selected.
   assign w_capture = dr_if.fsm_dr_select & dr_if.fsm_dr_capture;
   assign w_shift   = dr_if.fsm_dr_select & dr_if.fsm_dr_shift & ~dr_if.fsm_dr_capture;
   assign w_update  = dr_if.fsm_dr_select & dr_if.fsm_dr_update
                    & ~dr_if.fsm_dr_capture & ~dr_if.fsm_dr_shift
                    & (r_fsm != SCR1_TAPC_DR_IDLE);
   assign w_len_ok  = !SCR1_LEN_CHECK || (r_shift_cnt == LP_CNT_FULL);
   assign w_upd_ok  = w_update & w_len_ok;

   scr1_tapc_shift_core #(
      .SCR1_WIDTH       (SCR1_WIDTH),
      .SCR1_RESET_VALUE (SCR1_RESET_VALUE),
      .SCR1_MSB_FIRST   (SCR1_MSB_FIRST)
   ) u_core (
      .clk            (clk),
      .rst_n          (rst_n),
      .rst_n_sync     (rst_n_sync),
      .i_capture      (w_capture),
      .i_shift        (w_shift),
      .i_din_serial   (dr_if.din_serial),
      .i_din_parallel (dr_if.din_parallel),
      .o_stage        (w_stage),
      .o_dout_serial  (dr_if.dout_serial)
   );

   // Scan FSM, saturating bit counter and the update / length-error pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fsm            <= SCR1_TAPC_DR_IDLE;
         r_shift_cnt      <= '0;
         r_update_vld     <= 1'b0;
         r_len_err        <= 1'b0;
         r_len_err_sticky <= 1'b0;
      end else if (!rst_n_sync) begin
         r_fsm            <= SCR1_TAPC_DR_IDLE;
         r_shift_cnt      <= '0;
         r_update_vld     <= 1'b0;
         r_len_err        <= 1'b0;
         r_len_err_sticky <= 1'b0;
      end else begin
         r_update_vld <= 1'b0;
         r_len_err    <= 1'b0;
         if (w_capture) begin
            r_fsm            <= SCR1_TAPC_DR_CAPT;
            r_shift_cnt      <= '0;
            r_len_err_sticky <= 1'b0;
         end else if (w_shift) begin
            if (r_shift_cnt != LP_CNT_MAX) begin
               r_shift_cnt <= r_shift_cnt + {{(SCR1_CNT_W-1){1'b0}}, 1'b1};
            end else begin
               r_shift_cnt <= r_shift_cnt;
            end
            case (r_fsm)
               SCR1_TAPC_DR_CAPT,
               SCR1_TAPC_DR_SHIFT: r_fsm <= SCR1_TAPC_DR_SHIFT;
               default:            r_fsm <= r_fsm;
            endcase
         end else if (w_update) begin
            r_fsm <= SCR1_TAPC_DR_IDLE;
            if (w_len_ok) begin
               r_update_vld <= 1'b1;
            end else begin
               r_len_err        <= 1'b1;
               r_len_err_sticky <= 1'b1;
            end
         end else begin
            r_fsm <= r_fsm;
         end
      end
   end

   generate
      if (SCR1_UPDATE_EN) begin : g_shadow
         logic [SCR1_WIDTH-1:0] r_shadow;

         // Shadow stage follows the shift stage only on an accepted update.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_shadow <= SCR1_RESET_VALUE;
            end else if (!rst_n_sync) begin
               r_shadow <= SCR1_RESET_VALUE;
            end else if (w_upd_ok) begin
               r_shadow <= w_stage;
            end else begin
               r_shadow <= r_shadow;
            end
         end

         assign dr_if.dout_parallel = r_shadow;
      end else begin : g_no_shadow
         assign dr_if.dout_parallel = w_stage;
      end
   endgenerate

   assign dr_if.shift_cnt      = r_shift_cnt;
   assign dr_if.update_vld     = r_update_vld;
   assign dr_if.len_err        = r_len_err;
   assign dr_if.len_err_sticky = r_len_err_sticky;

   scr1_tapc_dr_shadow_reg_chk #(
      .SCR1_WIDTH (SCR1_WIDTH)
   ) u_chk (
      .clk            (clk),
      .rst_n          (rst_n),
      .rst_n_sync     (rst_n_sync),
      .fsm_dr_select  (dr_if.fsm_dr_select),
      .fsm_dr_capture (dr_if.fsm_dr_capture),
      .fsm_dr_shift   (dr_if.fsm_dr_shift),
      .fsm_dr_update  (dr_if.fsm_dr_update),
      .din_serial     (dr_if.din_serial),
      .din_parallel   (dr_if.din_parallel)
   );

endmodule

// File: tb/tb_scr1_tapc_dr_shadow_reg.sv
// Bench for scr1_tapc_dr_shadow_reg: an 8-bit LSB-first DR (a) and a 4-bit MSB-first DR (b)
// checked every cycle against a behavioural scan model plus directed literal expectations.
module tb_scr1_tapc_dr_shadow_reg;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rst_n_sync = 1'b1;
   logic [1:0] sel = '0, cap = '0, sh = '0, up = '0, tdi = '0;
   logic [7:0] par [2] = '{8'h00, 8'h00};
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   scr1_tapc_dr_shadow_reg_if #(.SCR1_WIDTH(8)) ifa ();
   scr1_tapc_dr_shadow_reg_if #(.SCR1_WIDTH(4)) ifb ();

   assign ifa.fsm_dr_select  = sel[0];
   assign ifa.fsm_dr_capture = cap[0];
   assign ifa.fsm_dr_shift   = sh[0];
   assign ifa.fsm_dr_update  = up[0];
   assign ifa.din_serial     = tdi[0];
   assign ifa.din_parallel   = par[0];
   assign ifb.fsm_dr_select  = sel[1];
   assign ifb.fsm_dr_capture = cap[1];
   assign ifb.fsm_dr_shift   = sh[1];
   assign ifb.fsm_dr_update  = up[1];
   assign ifb.din_serial     = tdi[1];
   assign ifb.din_parallel   = par[1][3:0];

   scr1_tapc_dr_shadow_reg #(
      .SCR1_WIDTH(8), .SCR1_RESET_VALUE(8'h00), .SCR1_UPDATE_EN(1'b1),
      .SCR1_MSB_FIRST(1'b0), .SCR1_LEN_CHECK(1'b1)
   ) u_dut_a (.clk(clk), .rst_n(rst_n), .rst_n_sync(rst_n_sync), .dr_if(ifa));

   scr1_tapc_dr_shadow_reg #(
      .SCR1_WIDTH(4), .SCR1_RESET_VALUE(4'h0), .SCR1_UPDATE_EN(1'b1),
      .SCR1_MSB_FIRST(1'b1), .SCR1_LEN_CHECK(1'b1)
   ) u_dut_b (.clk(clk), .rst_n(rst_n), .rst_n_sync(rst_n_sync), .dr_if(ifb));

   // Behavioural model: a scan is "open" after a capture and closed by the next update.
   function automatic int wd(input int i);
      return (i == 0) ? 8 : 4;
   endfunction
   function automatic int cmax(input int i);
      return (i == 0) ? 31 : 15;
   endfunction
   function automatic logic [7:0] shift_in(input logic [7:0] s, input logic b, input int i);
      int v;
      if (i == 1) v = ((int'(s) * 2) + int'(b)) % 16;
      else        v = (int'(s) / 2) + int'(b) * 128;
      return v[7:0];
   endfunction

   logic [7:0] m_stage [2];
   logic [7:0] m_shadow [2];
   int         m_cnt [2];
   logic [1:0] m_open, m_uv, m_le, m_sticky;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            m_stage[i] <= 8'h00; m_shadow[i] <= 8'h00; m_cnt[i] <= 0;
         end
         m_open <= '0; m_uv <= '0; m_le <= '0; m_sticky <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            m_uv[i] <= 1'b0;
            m_le[i] <= 1'b0;
            if (!rst_n_sync) begin
               m_stage[i] <= 8'h00; m_shadow[i] <= 8'h00; m_cnt[i] <= 0;
               m_open[i] <= 1'b0; m_sticky[i] <= 1'b0;
            end else if (sel[i] && cap[i]) begin
               m_stage[i] <= (i == 1) ? (par[i] & 8'h0F) : par[i];
               m_cnt[i] <= 0; m_sticky[i] <= 1'b0; m_open[i] <= 1'b1;
            end else if (sel[i] && sh[i]) begin
               m_stage[i] <= shift_in(m_stage[i], tdi[i], i);
               m_cnt[i] <= (m_cnt[i] >= cmax(i)) ? cmax(i) : m_cnt[i] + 1;
            end else if (sel[i] && up[i] && m_open[i]) begin
               m_open[i] <= 1'b0;
               if (m_cnt[i] == wd(i)) begin
                  m_shadow[i] <= m_stage[i]; m_uv[i] <= 1'b1;
               end else begin
                  m_le[i] <= 1'b1; m_sticky[i] <= 1'b1;
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model, away from the active edge.
   initial forever begin
      @(negedge clk);
      chk("a_tdo",    32'(ifa.dout_serial),    32'(m_stage[0][0]));
      chk("a_par",    32'(ifa.dout_parallel),  32'(m_shadow[0]));
      chk("a_cnt",    32'(ifa.shift_cnt),      32'(m_cnt[0]));
      chk("a_uv",     32'(ifa.update_vld),     32'(m_uv[0]));
      chk("a_le",     32'(ifa.len_err),        32'(m_le[0]));
      chk("a_sticky", 32'(ifa.len_err_sticky), 32'(m_sticky[0]));
      chk("b_tdo",    32'(ifb.dout_serial),    32'(m_stage[1][3]));
      chk("b_par",    32'(ifb.dout_parallel),  32'(m_shadow[1]));
      chk("b_cnt",    32'(ifb.shift_cnt),      32'(m_cnt[1]));
      chk("b_uv",     32'(ifb.update_vld),     32'(m_uv[1]));
      chk("b_le",     32'(ifb.len_err),        32'(m_le[1]));
      chk("b_sticky", 32'(ifb.len_err_sticky), 32'(m_sticky[1]));
   end

   task automatic drv(input int d, input logic s, input logic c, input logic h,
                      input logic u, input logic t, input logic [7:0] p);
      sel[d] = s; cap[d] = c; sh[d] = h; up[d] = u; tdi[d] = t; par[d] = p;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   logic [7:0] tdi_seq;
   logic [7:0] tdo_seq;

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_par", 32'(ifa.dout_parallel), 32'h00);
      chk("rst_cnt", 32'(ifa.shift_cnt), 32'd0);
      rst_n = 1'b1;
      tick();

      // Capture 0xA5, shift in 0x3C LSB-first, update.
      drv(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5); tick();
      tdi_seq = 8'h3C; tdo_seq = 8'b1010_0101;
      for (int k = 0; k < 8; k++) begin
         drv(0, 1'b1, 1'b0, 1'b1, 1'b0, tdi_seq[k], 8'h00);
         chk("t1_tdo", 32'(ifa.dout_serial), 32'(tdo_seq[k]));
         tick();
      end
      drv(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00); tick();
      chk("t1_uv", 32'(ifa.update_vld), 32'd1);
      chk("t1_par", 32'(ifa.dout_parallel), 32'h3C);
      chk("t1_le", 32'(ifa.len_err), 32'd0);
      drv(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); tick();
      chk("t1_uv_off", 32'(ifa.update_vld), 32'd0);

      // Short scan of 7 bits is rejected.
      drv(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11); tick();
      for (int k = 0; k < 7; k++) begin
         drv(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00); tick();
      end
      drv(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00); tick();
      chk("t2_le", 32'(ifa.len_err), 32'd1);
      chk("t2_sticky", 32'(ifa.len_err_sticky), 32'd1);
      chk("t2_par", 32'(ifa.dout_parallel), 32'h3C);
      drv(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); tick();
      chk("t2_le_off", 32'(ifa.len_err), 32'd0);
      chk("t2_sticky_hold", 32'(ifa.len_err_sticky), 32'd1);
      drv(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h22); tick();
      chk("t2_sticky_clr", 32'(ifa.len_err_sticky), 32'd0);

      // Overlong scan saturates the counter.
      for (int k = 0; k < 300; k++) begin
         drv(0, 1'b1, 1'b0, 1'b1, 1'b0, k[0], 8'h00); tick();
      end
      chk("t3_cnt_sat", 32'(ifa.shift_cnt), 32'd31);
      drv(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00); tick();
      chk("t3_le", 32'(ifa.len_err), 32'd1);

      // Capture wins over a simultaneous update; deselected update ignored; empty scan rejected.
      drv(0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h77); tick();
      chk("t5_uv", 32'(ifa.update_vld), 32'd0);
      chk("t5_le", 32'(ifa.len_err), 32'd0);
      chk("t5_par", 32'(ifa.dout_parallel), 32'h3C);
      drv(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00); tick();
      chk("t5_nosel_le", 32'(ifa.len_err), 32'd0);
      drv(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00); tick();
      chk("t5_zero_len", 32'(ifa.len_err), 32'd1);

      // Synchronous reset mid-shift.
      drv(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A); tick();
      for (int k = 0; k < 3; k++) begin
         drv(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00); tick();
      end
      rst_n_sync = 1'b0; tick();
      chk("t6_cnt", 32'(ifa.shift_cnt), 32'd0);
      chk("t6_par", 32'(ifa.dout_parallel), 32'h00);
      chk("t6_tdo", 32'(ifa.dout_serial), 32'd0);
      rst_n_sync = 1'b1;
      drv(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00); tick();
      chk("t6_uv", 32'(ifa.update_vld), 32'd0);
      chk("t6_le", 32'(ifa.len_err), 32'd0);
      drv(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

      // 4-bit MSB-first DR.
      drv(1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h09); tick();
      tdi_seq = 8'b0000_0011; tdo_seq = 8'b0000_1001;
      for (int k = 0; k < 4; k++) begin
         drv(1, 1'b1, 1'b0, 1'b1, 1'b0, tdi_seq[k], 8'h00);
         chk("t4_tdo", 32'(ifb.dout_serial), 32'(tdo_seq[k]));
         tick();
      end
      drv(1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00); tick();
      chk("t4_par", 32'(ifb.dout_parallel), 32'hC);
      chk("t4_uv", 32'(ifb.update_vld), 32'd1);
      drv(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

      // Asynchronous reset mid-scan.
      drv(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF); tick();
      chk("t7_tdo_pre", 32'(ifa.dout_serial), 32'd1);
      drv(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00); tick();
      drv(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      #2 rst_n = 1'b0;
      @(negedge clk);
      chk("t7_cnt", 32'(ifa.shift_cnt), 32'd0);
      chk("t7_tdo", 32'(ifa.dout_serial), 32'd0);
      rst_n = 1'b1;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
